// File: rtl/tcb_uart_pkg.sv
// Shared types for the TCB UART line engine.
// Contents: parity mode enum, TX/RX FSM state enums, RX status struct.
package tcb_uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10,
      PAR_RSVD = 2'b11
   } par_t;

   typedef enum logic [2:0] {
      TX_IDLE  = 3'd0,
      TX_START = 3'd1,
      TX_DATA  = 3'd2,
      TX_PAR   = 3'd3,
      TX_STOP  = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_PAR       = 3'd3,
      RX_STOP      = 3'd4,
      RX_WAIT_HIGH = 3'd5
   } rx_state_t;

   typedef struct packed {
      logic frm;
      logic par;
      logic brk;
   } rx_sts_t;

endpackage

// File: rtl/tcb_uart_bdr.sv
// Loadable bit-period down-counter.
// Ports: clk/rst, ld (load val), en (count), val (load and reload value),
//        wrp (strobe in the last cycle of a period; counter reloads val).
module tcb_uart_bdr
   import tcb_uart_pkg::*;
#(
   parameter int unsigned BDW = 16
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           ld,
   input  logic           en,
   input  logic [BDW-1:0] val,
   output logic           wrp
);

   localparam logic [BDW-1:0] CNT_ZERO = {BDW{1'b0}};
   localparam logic [BDW-1:0] CNT_ONE  = {{(BDW-1){1'b0}}, 1'b1};

   logic [BDW-1:0] cnt_r;

   assign wrp = en && !ld && (cnt_r == CNT_ZERO);

   // Period counter: load, reload on wrap, otherwise count down.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= CNT_ZERO;
      end else if (ld) begin
         cnt_r <= val;
      end else if (en) begin
         if (cnt_r == CNT_ZERO) begin
            cnt_r <= val;
         end else begin
            cnt_r <= cnt_r - CNT_ONE;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/tcb_uart_ser.sv
// UART serializer/deserializer with run-time data length, parity and stop bits.
// Ports: cfg_* line configuration (latched per frame); tx_vld/tx_dat/tx_rdy
//        TX stream, tx_bsy; rx_vld/rx_dat/rx_err_frm/rx_err_par/rx_brk/rx_rdy
//        RX stream with status, rx_ovr drop pulse, rx_bsy; uart_txd/uart_rxd line.
module tcb_uart_ser
   import tcb_uart_pkg::*;
#(
   parameter int unsigned DW  = 8,
   parameter int unsigned BDW = 16,
   parameter int unsigned SYN = 2
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BDW-1:0]        cfg_tx_bdr,
   input  logic [BDW-1:0]        cfg_rx_bdr,
   input  logic [BDW-1:0]        cfg_rx_smp,
   input  logic [$clog2(DW)-1:0] cfg_dlen,
   input  logic [1:0]            cfg_par,
   input  logic                  cfg_stp,
   input  logic                  tx_vld,
   input  logic [DW-1:0]         tx_dat,
   output logic                  tx_rdy,
   output logic                  tx_bsy,
   output logic                  rx_vld,
   output logic [DW-1:0]         rx_dat,
   output logic                  rx_err_frm,
   output logic                  rx_err_par,
   output logic                  rx_brk,
   input  logic                  rx_rdy,
   output logic                  rx_ovr,
   output logic                  rx_bsy,
   output logic                  uart_txd,
   input  logic                  uart_rxd
);

   localparam int unsigned     LW      = $clog2(DW);
   localparam logic [LW-1:0]   IDX_0   = {LW{1'b0}};
   localparam logic [LW-1:0]   IDX_1   = {{(LW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0]   DAT_0   = {DW{1'b0}};

   // Ones in bit positions 0..dlen.
   function automatic logic [DW-1:0] dat_mask(input logic [LW-1:0] dlen);
      logic [DW-1:0] m;
      for (int i = 0; i < DW; i++) begin
         m[i] = (i <= int'(dlen));
      end
      return m;
   endfunction

   // Parity bit for a data word whose unused upper bits are already zero.
   function automatic logic par_bit(input logic [DW-1:0] d, input par_t p);
      return (p == PAR_ODD) ? ~(^d) : (^d);
   endfunction

   function automatic logic par_on(input par_t p);
      return (p == PAR_EVEN) || (p == PAR_ODD);
   endfunction

   // ---------------- TX ----------------
   tx_state_t      tx_st_r, tx_st_s;
   logic [DW-1:0]  tx_sh_r, tx_sh_s;
   logic           tx_pbit_r, tx_pbit_s, tx_pen_r, tx_pen_s, tx_stp_r, tx_stp_s;
   logic [LW-1:0]  tx_dlen_r, tx_dlen_s, tx_idx_r, tx_idx_s;
   logic [BDW-1:0] tx_bdr_r, tx_bdr_s;
   logic           tx_sec_r, tx_sec_s, txd_r, txd_s;
   logic           tx_rdy_r, tx_rdy_s, tx_bsy_r, tx_bsy_s;
   logic           tx_ld_s, tx_wrp_s;

   tcb_uart_bdr #(.BDW(BDW)) u_tx_bdr (
      .clk (clk),
      .rst (rst),
      .ld  (tx_ld_s),
      .en  (tx_st_r != TX_IDLE),
      .val ((tx_st_r == TX_IDLE) ? cfg_tx_bdr : tx_bdr_r),
      .wrp (tx_wrp_s)
   );

   // TX next-state and next line value; one bit period per counter wrap.
   always_comb begin
      tx_st_s   = tx_st_r;
      tx_sh_s   = tx_sh_r;
      tx_pbit_s = tx_pbit_r;
      tx_pen_s  = tx_pen_r;
      tx_stp_s  = tx_stp_r;
      tx_dlen_s = tx_dlen_r;
      tx_bdr_s  = tx_bdr_r;
      tx_idx_s  = tx_idx_r;
      tx_sec_s  = tx_sec_r;
      txd_s     = txd_r;
      tx_ld_s   = 1'b0;
      case (tx_st_r)
         TX_IDLE: begin
            txd_s = 1'b1;
            if (tx_vld && tx_rdy_r) begin
               tx_sh_s   = tx_dat & dat_mask(cfg_dlen);
               tx_pbit_s = par_bit(tx_dat & dat_mask(cfg_dlen), par_t'(cfg_par));
               tx_pen_s  = par_on(par_t'(cfg_par));
               tx_stp_s  = cfg_stp;
               tx_dlen_s = cfg_dlen;
               tx_bdr_s  = cfg_tx_bdr;
               tx_idx_s  = IDX_0;
               tx_sec_s  = 1'b0;
               txd_s     = 1'b0;
               tx_ld_s   = 1'b1;
               tx_st_s   = TX_START;
            end else begin
               tx_st_s = TX_IDLE;
            end
         end
         TX_START: begin
            if (tx_wrp_s) begin
               txd_s   = tx_sh_r[0];
               tx_sh_s = {1'b0, tx_sh_r[DW-1:1]};
               tx_st_s = TX_DATA;
            end else begin
               tx_st_s = TX_START;
            end
         end
         TX_DATA: begin
            if (tx_wrp_s) begin
               if (tx_idx_r == tx_dlen_r) begin
                  if (tx_pen_r) begin
                     txd_s   = tx_pbit_r;
                     tx_st_s = TX_PAR;
                  end else begin
                     txd_s   = 1'b1;
                     tx_st_s = TX_STOP;
                  end
               end else begin
                  tx_idx_s = tx_idx_r + IDX_1;
                  txd_s    = tx_sh_r[0];
                  tx_sh_s  = {1'b0, tx_sh_r[DW-1:1]};
               end
            end else begin
               tx_st_s = TX_DATA;
            end
         end
         TX_PAR: begin
            if (tx_wrp_s) begin
               txd_s   = 1'b1;
               tx_st_s = TX_STOP;
            end else begin
               tx_st_s = TX_PAR;
            end
         end
         TX_STOP: begin
            txd_s = 1'b1;
            if (tx_wrp_s) begin
               if (tx_stp_r && !tx_sec_r) begin
                  tx_sec_s = 1'b1;
               end else begin
                  tx_st_s = TX_IDLE;
               end
            end else begin
               tx_st_s = TX_STOP;
            end
         end
         default: begin
            txd_s   = 1'b1;
            tx_st_s = TX_IDLE;
         end
      endcase
      tx_rdy_s = (tx_st_s == TX_IDLE);
      tx_bsy_s = (tx_st_s != TX_IDLE);
   end

   // TX state and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_st_r   <= TX_IDLE;
         tx_sh_r   <= DAT_0;
         tx_pbit_r <= 1'b0;
         tx_pen_r  <= 1'b0;
         tx_stp_r  <= 1'b0;
         tx_dlen_r <= IDX_0;
         tx_bdr_r  <= {BDW{1'b0}};
         tx_idx_r  <= IDX_0;
         tx_sec_r  <= 1'b0;
         txd_r     <= 1'b1;
         tx_rdy_r  <= 1'b0;
         tx_bsy_r  <= 1'b0;
      end else begin
         tx_st_r   <= tx_st_s;
         tx_sh_r   <= tx_sh_s;
         tx_pbit_r <= tx_pbit_s;
         tx_pen_r  <= tx_pen_s;
         tx_stp_r  <= tx_stp_s;
         tx_dlen_r <= tx_dlen_s;
         tx_bdr_r  <= tx_bdr_s;
         tx_idx_r  <= tx_idx_s;
         tx_sec_r  <= tx_sec_s;
         txd_r     <= txd_s;
         tx_rdy_r  <= tx_rdy_s;
         tx_bsy_r  <= tx_bsy_s;
      end
   end

   assign uart_txd = txd_r;
   assign tx_rdy   = tx_rdy_r;
   assign tx_bsy   = tx_bsy_r;

   // ---------------- RX ----------------
   logic [SYN-1:0] sync_r;
   logic           rxd_s;
   rx_state_t      rx_st_r, rx_st_s;
   logic [BDW-1:0] rx_bdr_r, rx_bdr_s;
   logic [LW-1:0]  rx_dlen_r, rx_dlen_s, rx_idx_r, rx_idx_s;
   par_t           rx_par_r, rx_par_s;
   logic [DW-1:0]  rx_sh_r, rx_sh_s, rx_dat_r, rx_dat_s;
   logic           rx_one_r, rx_one_s, rx_perr_r, rx_perr_s;
   logic           rx_vld_r, rx_vld_s, rx_ovr_r, rx_ovr_s, rx_bsy_r, rx_bsy_s;
   rx_sts_t        rx_sts_r, rx_sts_s;
   logic           rx_ld_s, rx_wrp_s;

   assign rxd_s = sync_r[SYN-1];

   // Line synchronizer, idles high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= {SYN{1'b1}};
      end else begin
         sync_r <= {sync_r[SYN-2:0], uart_rxd};
      end
   end

   // First period after start detection uses the mid-bit delay, then bit periods.
   tcb_uart_bdr #(.BDW(BDW)) u_rx_bdr (
      .clk (clk),
      .rst (rst),
      .ld  (rx_ld_s),
      .en  ((rx_st_r != RX_IDLE) && (rx_st_r != RX_WAIT_HIGH)),
      .val ((rx_st_r == RX_IDLE) ? cfg_rx_smp : rx_bdr_r),
      .wrp (rx_wrp_s)
   );

   // RX next-state, sampling and output handshake.
   always_comb begin
      rx_st_s   = rx_st_r;
      rx_bdr_s  = rx_bdr_r;
      rx_dlen_s = rx_dlen_r;
      rx_par_s  = rx_par_r;
      rx_idx_s  = rx_idx_r;
      rx_sh_s   = rx_sh_r;
      rx_one_s  = rx_one_r;
      rx_perr_s = rx_perr_r;
      rx_dat_s  = rx_dat_r;
      rx_sts_s  = rx_sts_r;
      rx_vld_s  = rx_vld_r && !rx_rdy;
      rx_ovr_s  = 1'b0;
      rx_ld_s   = 1'b0;
      case (rx_st_r)
         RX_IDLE: begin
            if (!rxd_s) begin
               rx_bdr_s  = cfg_rx_bdr;
               rx_dlen_s = cfg_dlen;
               rx_par_s  = par_t'(cfg_par);
               rx_idx_s  = IDX_0;
               rx_sh_s   = DAT_0;
               rx_one_s  = 1'b0;
               rx_perr_s = 1'b0;
               rx_ld_s   = 1'b1;
               rx_st_s   = RX_START;
            end else begin
               rx_st_s = RX_IDLE;
            end
         end
         RX_START: begin
            if (rx_wrp_s) begin
               rx_st_s = rxd_s ? RX_IDLE : RX_DATA;
            end else begin
               rx_st_s = RX_START;
            end
         end
         RX_DATA: begin
            if (rx_wrp_s) begin
               rx_sh_s[rx_idx_r] = rxd_s;
               rx_one_s          = rx_one_r | rxd_s;
               if (rx_idx_r == rx_dlen_r) begin
                  rx_st_s = par_on(rx_par_r) ? RX_PAR : RX_STOP;
               end else begin
                  rx_idx_s = rx_idx_r + IDX_1;
               end
            end else begin
               rx_st_s = RX_DATA;
            end
         end
         RX_PAR: begin
            if (rx_wrp_s) begin
               rx_perr_s = rxd_s ^ par_bit(rx_sh_r, rx_par_r);
               rx_one_s  = rx_one_r | rxd_s;
               rx_st_s   = RX_STOP;
            end else begin
               rx_st_s = RX_PAR;
            end
         end
         RX_STOP: begin
            if (rx_wrp_s) begin
               // A consumer taking the old character this cycle frees the slot.
               if (rx_vld_r && !rx_rdy) begin
                  rx_ovr_s = 1'b1;
               end else begin
                  rx_vld_s     = 1'b1;
                  rx_dat_s     = rx_sh_r;
                  rx_sts_s.frm = ~rxd_s;
                  rx_sts_s.par = rx_perr_r;
                  rx_sts_s.brk = ~rx_one_r & ~rxd_s;
               end
               // A low stop bit may be a break; rearm only once the line is high.
               rx_st_s = rxd_s ? RX_IDLE : RX_WAIT_HIGH;
            end else begin
               rx_st_s = RX_STOP;
            end
         end
         RX_WAIT_HIGH: begin
            if (rxd_s) begin
               rx_st_s = RX_IDLE;
            end else begin
               rx_st_s = RX_WAIT_HIGH;
            end
         end
         default: begin
            rx_st_s = RX_IDLE;
         end
      endcase
      rx_bsy_s = (rx_st_s != RX_IDLE);
   end

   // RX state and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_st_r   <= RX_IDLE;
         rx_bdr_r  <= {BDW{1'b0}};
         rx_dlen_r <= IDX_0;
         rx_par_r  <= PAR_NONE;
         rx_idx_r  <= IDX_0;
         rx_sh_r   <= DAT_0;
         rx_one_r  <= 1'b0;
         rx_perr_r <= 1'b0;
         rx_dat_r  <= DAT_0;
         rx_sts_r  <= 3'b000;
         rx_vld_r  <= 1'b0;
         rx_ovr_r  <= 1'b0;
         rx_bsy_r  <= 1'b0;
      end else begin
         rx_st_r   <= rx_st_s;
         rx_bdr_r  <= rx_bdr_s;
         rx_dlen_r <= rx_dlen_s;
         rx_par_r  <= rx_par_s;
         rx_idx_r  <= rx_idx_s;
         rx_sh_r   <= rx_sh_s;
         rx_one_r  <= rx_one_s;
         rx_perr_r <= rx_perr_s;
         rx_dat_r  <= rx_dat_s;
         rx_sts_r  <= rx_sts_s;
         rx_vld_r  <= rx_vld_s;
         rx_ovr_r  <= rx_ovr_s;
         rx_bsy_r  <= rx_bsy_s;
      end
   end

   assign rx_vld     = rx_vld_r;
   assign rx_dat     = rx_dat_r;
   assign rx_err_frm = rx_sts_r.frm;
   assign rx_err_par = rx_sts_r.par;
   assign rx_brk     = rx_sts_r.brk;
   assign rx_ovr     = rx_ovr_r;
   assign rx_bsy     = rx_bsy_r;

endmodule

// File: tb/tb_tcb_uart_ser.sv
// Directed bench for tcb_uart_ser: bit periods of 4 cycles, mid-bit delay 2.
module tb_tcb_uart_ser;

   localparam int DW  = 8;
   localparam int BDW = 16;
   localparam int SYN = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [BDW-1:0] cfg_tx_bdr = 16'd3;
   logic [BDW-1:0] cfg_rx_bdr = 16'd3;
   logic [BDW-1:0] cfg_rx_smp = 16'd1;
   logic [2:0]     cfg_dlen   = 3'd7;
   logic [1:0]     cfg_par    = 2'b00;
   logic           cfg_stp    = 1'b0;
   logic           tx_vld     = 1'b0;
   logic [DW-1:0]  tx_dat     = 8'h00;
   logic           tx_rdy, tx_bsy, rx_vld, rx_err_frm, rx_err_par, rx_brk, rx_ovr, rx_bsy;
   logic [DW-1:0]  rx_dat;
   logic           rx_rdy  = 1'b0;
   logic           uart_txd, uart_rxd;
   logic           lpbk    = 1'b0;
   logic           rxd_drv = 1'b1;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int ovr_cnt  = 0;

   assign uart_rxd = lpbk ? uart_txd : rxd_drv;

   tcb_uart_ser #(.DW(DW), .BDW(BDW), .SYN(SYN)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_tx_bdr (cfg_tx_bdr),
      .cfg_rx_bdr (cfg_rx_bdr),
      .cfg_rx_smp (cfg_rx_smp),
      .cfg_dlen   (cfg_dlen),
      .cfg_par    (cfg_par),
      .cfg_stp    (cfg_stp),
      .tx_vld     (tx_vld),
      .tx_dat     (tx_dat),
      .tx_rdy     (tx_rdy),
      .tx_bsy     (tx_bsy),
      .rx_vld     (rx_vld),
      .rx_dat     (rx_dat),
      .rx_err_frm (rx_err_frm),
      .rx_err_par (rx_err_par),
      .rx_brk     (rx_brk),
      .rx_rdy     (rx_rdy),
      .rx_ovr     (rx_ovr),
      .rx_bsy     (rx_bsy),
      .uart_txd   (uart_txd),
      .uart_rxd   (uart_rxd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rx_ovr) ovr_cnt <= ovr_cnt + 1;
   end

   task automatic set_cfg(input logic [2:0] dlen, input logic [1:0] par, input logic stp);
      cfg_dlen = dlen;
      cfg_par  = par;
      cfg_stp  = stp;
   endtask

   // Present a character and hold it until accepted; t is the accept edge count.
   task automatic tx_send(input logic [7:0] d, output int t);
      @(negedge clk);
      tx_vld = 1'b1;
      tx_dat = d;
      t = -1;
      for (int i = 0; i < 200; i++) begin
         if (tx_rdy) begin
            t = cyc;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      tx_vld = 1'b0;
      if (t < 0) begin
         checks++;
         failures++;
         $display("FAIL tx_accept_timeout: tx_rdy never seen");
      end
   endtask

   // Send a character and compare the line cycle by cycle against exp (bit 0 = start).
   task automatic tx_frame(input logic [7:0] d, input int nb, input logic [15:0] exp, input string name);
      int t;
      int mis = 0;
      int first = -1;
      tx_send(d, t);
      for (int k = 1; k <= nb * 4; k++) begin
         if (uart_txd !== exp[(k - 1) / 4]) begin
            mis++;
            if (first < 0) first = k;
         end
         if (k < nb * 4) @(negedge clk);
      end
      checks++;
      if (mis != 0) begin
         failures++;
         $display("FAIL %s_txd: %0d cycles wrong, first at cycle %0d, required frame %b", name, mis, first, exp);
      end
      checks++;
      if (tx_rdy !== 1'b0 || tx_bsy !== 1'b1) begin
         failures++;
         $display("FAIL %s_last_stop: tx_rdy=%b tx_bsy=%b required 0/1", name, tx_rdy, tx_bsy);
      end
      @(negedge clk);
      checks++;
      if (tx_rdy !== 1'b1 || tx_bsy !== 1'b0 || uart_txd !== 1'b1) begin
         failures++;
         $display("FAIL %s_idle: tx_rdy=%b tx_bsy=%b txd=%b required 1/0/1", name, tx_rdy, tx_bsy, uart_txd);
      end
   endtask

   // Drive nb serial bits (bit 0 first) on rxd, 4 cycles each, then idle high.
   task automatic drive_bits(input logic [15:0] bits, input int nb);
      for (int i = 0; i < nb; i++) begin
         rxd_drv = bits[i];
         repeat (4) @(negedge clk);
      end
      rxd_drv = 1'b1;
   endtask

   // Wait (bounded) for rx_vld, then compare character and status.
   task automatic check_rx(input string name, input logic [7:0] d, input logic frm, input logic par, input logic brk);
      int n = 0;
      while (rx_vld !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rx_vld !== 1'b1) begin
         failures++;
         $display("FAIL %s_rx_vld: timed out, rx_vld=%b required 1", name, rx_vld);
      end else if (rx_dat !== d || rx_err_frm !== frm || rx_err_par !== par || rx_brk !== brk) begin
         failures++;
         $display("FAIL %s_rx: dat=%h frm=%b par=%b brk=%b required dat=%h frm=%b par=%b brk=%b",
                  name, rx_dat, rx_err_frm, rx_err_par, rx_brk, d, frm, par, brk);
      end
   endtask

   task automatic consume(input string name);
      @(negedge clk);
      rx_rdy = 1'b1;
      @(negedge clk);
      rx_rdy = 1'b0;
      checks++;
      if (rx_vld !== 1'b0) begin
         failures++;
         $display("FAIL %s_consume: rx_vld=%b required 0", name, rx_vld);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (uart_txd !== 1'b1 || tx_rdy !== 1'b0 || tx_bsy !== 1'b0 || rx_bsy !== 1'b0) begin
         failures++;
         $display("FAIL reset_tx: txd=%b tx_rdy=%b tx_bsy=%b rx_bsy=%b required 1/0/0/0", uart_txd, tx_rdy, tx_bsy, rx_bsy);
      end
      checks++;
      if (rx_vld !== 1'b0 || rx_dat !== 8'h00 || rx_err_frm !== 1'b0 || rx_err_par !== 1'b0 ||
          rx_brk !== 1'b0 || rx_ovr !== 1'b0) begin
         failures++;
         $display("FAIL reset_rx: vld=%b dat=%h frm=%b par=%b brk=%b ovr=%b required all 0",
                  rx_vld, rx_dat, rx_err_frm, rx_err_par, rx_brk, rx_ovr);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (tx_rdy !== 1'b1 || uart_txd !== 1'b1) begin
         failures++;
         $display("FAIL reset_release: tx_rdy=%b txd=%b required 1/1", tx_rdy, uart_txd);
      end
   endtask

   task automatic test_8n1_loop();
      set_cfg(3'd7, 2'b00, 1'b0);
      lpbk = 1'b1;
      tx_frame(8'h55, 10, 16'h02AA, "8n1_55");
      check_rx("8n1_55", 8'h55, 1'b0, 1'b0, 1'b0);
      consume("8n1_55");
   endtask

   task automatic test_7e2_loop();
      set_cfg(3'd6, 2'b01, 1'b1);
      lpbk = 1'b1;
      tx_frame(8'h41, 11, 16'h0682, "7e2_41");
      check_rx("7e2_41", 8'h41, 1'b0, 1'b0, 1'b0);
      consume("7e2_41");
   endtask

   task automatic test_parity_err();
      lpbk = 1'b0;
      set_cfg(3'd7, 2'b10, 1'b0);
      @(negedge clk);
      // 0xA3 with parity bit 0 where odd parity requires 1
      drive_bits(16'h0546, 11);
      check_rx("8o1_a3", 8'hA3, 1'b0, 1'b1, 1'b0);
      consume("8o1_a3");
   endtask

   task automatic test_break();
      int nv = 0;
      logic [7:0] bdat = 8'hFF;
      logic bfrm = 1'b0, bbrk = 1'b0;
      lpbk = 1'b0;
      set_cfg(3'd7, 2'b00, 1'b0);
      rx_rdy = 1'b1;
      @(negedge clk);
      rxd_drv = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (rx_vld) begin
            nv++;
            bdat = rx_dat;
            bfrm = rx_err_frm;
            bbrk = rx_brk;
         end
      end
      checks++;
      if (nv != 1 || bdat !== 8'h00 || bfrm !== 1'b1 || bbrk !== 1'b1) begin
         failures++;
         $display("FAIL break_char: count=%0d dat=%h frm=%b brk=%b required 1/00/1/1", nv, bdat, bfrm, bbrk);
      end
      checks++;
      if (rx_bsy !== 1'b1) begin
         failures++;
         $display("FAIL break_hold: rx_bsy=%b required 1 while line low", rx_bsy);
      end
      rxd_drv = 1'b1;
      rx_rdy  = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (rx_bsy !== 1'b0) begin
         failures++;
         $display("FAIL break_release: rx_bsy=%b required 0", rx_bsy);
      end
      drive_bits(16'h02B4, 10);
      check_rx("after_break_5a", 8'h5A, 1'b0, 1'b0, 1'b0);
      consume("after_break_5a");
   endtask

   task automatic test_back_to_back();
      int t1, t2, o0;
      lpbk = 1'b1;
      set_cfg(3'd7, 2'b00, 1'b0);
      rx_rdy = 1'b0;
      o0 = ovr_cnt;
      tx_send(8'h11, t1);
      tx_send(8'h22, t2);
      checks++;
      if (t2 - t1 != 41) begin
         failures++;
         $display("FAIL b2b_period: %0d cycles required 41", t2 - t1);
      end
      repeat (60) @(negedge clk);
      checks++;
      if (ovr_cnt - o0 != 1 || rx_vld !== 1'b1 || rx_dat !== 8'h11) begin
         failures++;
         $display("FAIL overrun: ovr_pulses=%0d vld=%b dat=%h required 1/1/11", ovr_cnt - o0, rx_vld, rx_dat);
      end
      consume("overrun");
   endtask

   task automatic test_glitch();
      int nv = 0;
      logic seen = 1'b0;
      lpbk = 1'b0;
      @(negedge clk);
      rxd_drv = 1'b0;
      @(negedge clk);
      rxd_drv = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rx_bsy) seen = 1'b1;
         if (rx_vld) nv++;
      end
      checks++;
      if (nv != 0 || seen !== 1'b1 || rx_bsy !== 1'b0) begin
         failures++;
         $display("FAIL glitch: vld_cycles=%0d bsy_seen=%b bsy_now=%b required 0/1/0", nv, seen, rx_bsy);
      end
   endtask

   task automatic test_reset_mid_tx();
      int t;
      lpbk = 1'b0;
      set_cfg(3'd7, 2'b00, 1'b0);
      tx_send(8'hC3, t);
      // now in cycle 1 of the frame; cycle 13 lies inside data bit 2 (0)
      repeat (12) @(negedge clk);
      checks++;
      if (uart_txd !== 1'b0 || tx_bsy !== 1'b1) begin
         failures++;
         $display("FAIL midtx_data: txd=%b tx_bsy=%b required 0/1", uart_txd, tx_bsy);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (uart_txd !== 1'b1 || tx_rdy !== 1'b0 || tx_bsy !== 1'b0) begin
         failures++;
         $display("FAIL midtx_reset: txd=%b tx_rdy=%b tx_bsy=%b required 1/0/0", uart_txd, tx_rdy, tx_bsy);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (tx_rdy !== 1'b1) begin
         failures++;
         $display("FAIL midtx_release: tx_rdy=%b required 1", tx_rdy);
      end
      tx_frame(8'h3C, 10, 16'h0278, "after_rst_3c");
   endtask

   initial begin
      test_reset();
      test_8n1_loop();
      test_7e2_loop();
      test_parity_err();
      test_break();
      test_back_to_back();
      test_glitch();
      test_reset_mid_tx();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
